// File: rtl/seq_mul.sv
// Multi-cycle unsigned shift-add multiplier with valid/ready handshakes.
// Exactly DATAWIDTH iterations per operation, regardless of operand values.
module seq_mul #(
    parameter int DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAWIDTH-1:0]   prod,
    output logic [2*DATAWIDTH-1:0] prod_full,
    output logic                   ovf
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | one shift-add iteration per cycle, DATAWIDTH cycles
    // DONE  | result held, out_valid high until out_ready

    localparam int CW = $clog2(DATAWIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [2*DATAWIDTH-1:0] mcand;
    logic [2*DATAWIDTH-1:0] acc;
    logic [2*DATAWIDTH-1:0] acc_next;
    logic [DATAWIDTH-1:0]   mplier;
    logic [CW-1:0]          cnt;

    // acc never exceeds (2^W-1)^2, so the 2W-bit add cannot overflow
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            prod      <= '0;
            prod_full <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{DATAWIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        prod_full <= acc_next;
                        prod      <= acc_next[DATAWIDTH-1:0];
                        ovf       <= |acc_next[2*DATAWIDTH-1:DATAWIDTH];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: stimulus queues expected results, monitors
// compare on each rising out_valid (8-bit and 16-bit instances).
module tb_seq_mul;
    typedef struct {
        logic [31:0] full;
        logic [15:0] p;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v8, rdy8, ov8, or8, ovf8;
    logic [7:0]  a8, b8, p8;
    logic [15:0] pf8;
    logic        v16, rdy16, ov16, or16, ovf16;
    logic [15:0] a16, b16, p16;
    logic [31:0] pf16;

    seq_mul #(.DATAWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .prod(p8), .prod_full(pf8), .ovf(ovf8));

    seq_mul #(.DATAWIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .prod(p16), .prod_full(pf16), .ovf(ovf16));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int last_acc = 0, prev_acc = 0;
    exp_t exp8[$], exp16[$];
    int acc8[$], acc16[$];
    logic ov8_q = 1'b0, ov16_q = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // accept tracker: edge numbering shared with the monitors
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && v8 && rdy8) begin
            acc8.push_back(cyc);
            prev_acc = last_acc;
            last_acc = cyc;
            n_acc++;
        end
        if (rst_n && v16 && rdy16) acc16.push_back(cyc);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov8 && !ov8_q) begin
            if (exp8.size() == 0) check("unexpected_out_valid8", 1, 0);
            else begin
                e = exp8.pop_front();
                check("prod_full8", pf8, e.full);
                check("prod8", p8, e.p);
                check("ovf8", ovf8, e.o);
                if (acc8.size() > 0) check("latency8", cyc - acc8.pop_front(), 8);
            end
        end
        ov8_q = ov8;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov16 && !ov16_q) begin
            if (exp16.size() == 0) check("unexpected_out_valid16", 1, 0);
            else begin
                e = exp16.pop_front();
                check("prod_full16", pf16, e.full);
                check("prod16", p16, e.p);
                check("ovf16", ovf16, e.o);
                if (acc16.size() > 0) check("latency16", cyc - acc16.pop_front(), 16);
            end
        end
        ov16_q = ov16;
    end

    task automatic push8(input logic [15:0] full, input logic [7:0] p, input logic o);
        exp_t e;
        e.full = {16'h0, full};
        e.p    = {8'h0, p};
        e.o    = o;
        exp8.push_back(e);
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] full, input logic [7:0] p, input logic o);
        @(negedge clk);
        a8 = x; b8 = y; v8 = 1'b1;
        push8(full, p, o);
        @(negedge clk);
        v8 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp8.size() != 0 || exp16.size() != 0 || !rdy8 || !rdy16) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int n0, t, seen;
        exp_t e;
        rst_n = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        #3 rst_n = 1'b0;
        #10;
        check("rst_in_ready", rdy8, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_prod_full", pf8, 0);
        check("rst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue8(8'd13, 8'd11, 16'h008F, 8'h8F, 1'b0);
        wait_drain();
        issue8(8'd255, 8'd255, 16'hFE01, 8'h01, 1'b1);
        wait_drain();
        issue8(8'd16, 8'd16, 16'h0100, 8'h00, 1'b1);
        wait_drain();

        issue8(8'd0, 8'd200, 16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("in_ready_low_in_run", rdy8, 0);
            @(negedge clk);
        end
        wait_drain();
        issue8(8'd200, 8'd0, 16'h0000, 8'h00, 1'b0);
        wait_drain();

        // backpressure with an ignored in_valid pulse
        or8 = 1'b0;
        issue8(8'd7, 8'd9, 16'd63, 8'd63, 1'b0);
        t = 0;
        while (!ov8 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("bp_wait_timeout", 0, 1);
        n0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", ov8, 1);
            check("bp_prod", p8, 63);
            check("bp_prod_full", pf8, 63);
            if (i == 1) begin v8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
            if (i == 2) v8 = 1'b0;
            @(negedge clk);
        end
        check("bp_no_accept", n_acc - n0, 0);
        or8 = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", rdy8, 1);
        check("bp_release_out_valid", ov8, 0);
        wait_drain();

        // held in_valid: back-to-back accepts 10 cycles apart
        @(negedge clk);
        n0 = n_acc;
        a8 = 8'd3; b8 = 8'd5; v8 = 1'b1;
        push8(16'd15, 8'd15, 1'b0);
        push8(16'd200, 8'd200, 1'b0);
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd20;
        t = 0;
        while (n_acc < n0 + 2 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("held_accept_timeout", 0, 1);
        v8 = 1'b0;
        check("held_accept_spacing", last_acc - prev_acc, 10);
        wait_drain();

        // reset abort mid-RUN
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", rdy8, 1);
        check("abort_out_valid", ov8, 0);
        check("abort_prod", p8, 0);
        check("abort_prod_full", pf8, 0);
        check("abort_ovf", ovf8, 0);
        acc8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        check("abort_no_out_valid", seen, 0);

        // 16-bit instance
        @(negedge clk);
        a16 = 16'd13; b16 = 16'd11; v16 = 1'b1;
        e.full = 32'd143; e.p = 16'd143; e.o = 1'b0;
        exp16.push_back(e);
        @(negedge clk);
        v16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
        wait_drain();

        check("pending_expected", exp8.size() + exp16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
